ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- AHB-Lite initiator for the USB endpoint's AHB slave state controller.
- Turns simple one-at-a-time command requests from the bench/host model into correctly phased AHB-Lite transfers: address phase, then data phase.
- Waits out slave wait states, handles the two-cycle ERROR response, and returns read data or error status on a response strobe.
- Single outstanding transfer; exercises the slave's IDLE/WRITE/READ/ERROR paths from the master side.

Parameters:
ADDR_WIDTH, 7, haddr/cmd_addr width (matches slave address map)
DATA_WIDTH, 32, hwdata/hrdata/cmd data width; fixed 32, lane logic assumes 4 byte lanes

Ports:
clk  input  1  system clock, rising-edge
nRst  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  master can accept a command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  byte address
cmd_size  input  2  00 byte, 01 half, 10 word, 11 forwarded unchanged (slave must error)
cmd_wdata  input  DATA_WIDTH  write data, LSB-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_WIDTH  read data, LSB-justified, zero-extended
rsp_error  output  1  slave signalled ERROR (valid with rsp_valid)
hsel  output  1  slave select
haddr  output  ADDR_WIDTH  AHB address
htrans  output  2  00 IDLE, 10 NONSEQ
hsize  output  2  transfer size
hwrite  output  1  transfer direction
hwdata  output  DATA_WIDTH  write data, lane-steered
hrdata  input  DATA_WIDTH  read data
hready  input  1  slave ready
hresp  input  1  slave error response

Behaviour:
- Clock and reset: one clock, clk; reset nRst, asynchronous, active-low.
- Reset values, applied immediately on nRst low, including mid-transfer:
  - state IDLE; cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0.
  - hsel=0, htrans=00, haddr=0, hsize=0, hwrite=0, hwdata=0.
  - No partial response is issued.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE:
  - cmd_ready=1.
  - On a clock edge with cmd_valid=1, capture cmd_*; go to ADDR.
- ADDR:
  - Registered outputs: hsel=1, htrans=10, and haddr/hsize/hwrite from the captured command.
  - On an edge with hready=1, go to DATA. Otherwise hold all address-phase outputs stable.
- DATA:
  - htrans=00, hsel=0; hwdata driven from the captured, lane-steered wdata, held until exit.
  - hready=1, hresp=0: complete. Go to IDLE; rsp_valid=1 next cycle with rsp_error=0.
  - hready=0, hresp=1: go to ERR.
  - hready=1, hresp=1 (one-cycle error, protocol violation): complete with rsp_error=1.
  - hready=0, hresp=0: wait state; stay in DATA. No limit on wait states.
- ERR:
  - On an edge with hready=1, go to IDLE; rsp_valid=1, rsp_error=1.
  - While hready=0, stay in ERR.
- cmd_ready=0 in ADDR, DATA and ERR. Commands presented then are ignored; the requester must hold cmd_valid.
- Completion latency: a zero-wait transfer accepted at edge N has rsp_valid high in the cycle after edge N+2. Minimum 3 cycles per transfer.
- rsp_valid is a one-cycle pulse. rsp_rdata and rsp_error are held until the next response.
  - Writes report rsp_rdata=0.
  - On a read completion, hrdata is sampled at the completing edge.
- Lane steering (little-endian), with lane = haddr[1:0]:
  - Byte: hwdata = wdata[7:0] << 8*lane; read = hrdata >> 8*lane, masked to 8 bits.
  - Half: lane offset haddr[1]*16; 16-bit mask.
  - Word: no shift.
  - Size 11: treated as word for steering, forwarded as-is.
  - Misaligned addresses are not checked locally; they are forwarded.
- cmd_valid during the rsp_valid cycle is accepted, because the master is back in IDLE.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10.
  - HSIZE_BYTE/HALF/WORD.
  - Master state enum typedef (IDLE, ADDR, DATA, ERR).
- Sub-module ahb_lane_steer: purely combinational write-shift and read-extract, inputs size and addr[1:0].
- FSM, command capture and response registers stay in ahb_lite_master.

Test Plan:
1. Reset: nRst low 2 cycles → htrans=00, hsel=0, cmd_ready=1, rsp_valid=0. Assert nRst mid-DATA → immediate return to these values, no rsp_valid.
2. Word write, addr 0x00, wdata 0xDEADBEEF, size 10, hready=1:
   - Next cycle: htrans=10, haddr=0x00, hwrite=1, hsize=10.
   - Following cycle: htrans=00, hwdata=0xDEADBEEF.
   - Then rsp_valid=1, rsp_error=0.
3. Byte write, addr 0x23, wdata 0x000000A5, size 00 → hwdata=0xA5000000 in the data phase; hsize=00.
4. Half read, addr 0x42, slave hready=0 for 2 cycles then hrdata=0x12345678 with hready=1 → rsp_valid only after hready rises; rsp_rdata=0x00001234.
5. Error, write addr 0x15 size 11; slave responds hresp=1/hready=0, then hresp=1/hready=1 → state ERR for 1 cycle; rsp_valid=1, rsp_error=1; cmd_ready=1 in the same cycle. A subsequent read at 0x48 completes normally.
6. Back-to-back: cmd_valid held high for 3 writes (0x00, 0x23, 0x3F) → each accepted only in IDLE, 3 cycles apart, with 3 rsp_valid pulses in order.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer encodings and master state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HSIZE_BYTE = 2'b00;
  localparam logic [1:0] HSIZE_HALF = 2'b01;
  localparam logic [1:0] HSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    MST_IDLE = 2'b00,
    MST_ADDR = 2'b01,
    MST_DATA = 2'b10,
    MST_ERR  = 2'b11
  } mst_state_e;

endpackage

// File: rtl/ahb_lane_steer.sv
// rtl/ahb_lane_steer.sv - little-endian byte-lane steering for AHB write and read data
module ahb_lane_steer
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};

  logic [4:0] shamt;

  always_comb begin
    shamt  = 5'd0;
    hwdata = wdata;
    rdata  = hrdata;
    case (size)
      HSIZE_BYTE: begin
        shamt  = {addr_lo, 3'b000};
        hwdata = (wdata & BYTE_MASK) << shamt;
        rdata  = (hrdata >> shamt) & BYTE_MASK;
      end
      HSIZE_HALF: begin
        shamt  = {addr_lo[1], 4'b0000};
        hwdata = (wdata & HALF_MASK) << shamt;
        rdata  = (hrdata >> shamt) & HALF_MASK;
      end
      // Word and the illegal size 11 both pass straight through.
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - single-outstanding AHB-Lite initiator driven by a command/response port
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic [1:0]            hsize,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  mst_state_e            state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  hsel_q, hsel_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [1:0]            hsize_q, hsize_d;
  logic                  hwrite_q, hwrite_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0] wdata_steered;
  logic [DATA_WIDTH-1:0] rdata_steered;

  ahb_lane_steer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_steer (
    .size    (hsize_q),
    .addr_lo (haddr_q[1:0]),
    .wdata   (wdata_q),
    .hrdata  (hrdata),
    .hwdata  (wdata_steered),
    .rdata   (rdata_steered)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    hsel_d      = hsel_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;

    case (state_q)
      MST_IDLE: begin
        if (cmd_valid) begin
          state_d     = MST_ADDR;
          cmd_ready_d = 1'b0;
          hsel_d      = 1'b1;
          htrans_d    = HTRANS_NONSEQ;
          haddr_d     = cmd_addr;
          hsize_d     = cmd_size;
          hwrite_d    = cmd_write;
          wdata_d     = cmd_wdata;
        end
      end
      MST_ADDR: begin
        if (hready) begin
          state_d  = MST_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_steered;
        end
      end
      MST_DATA: begin
        if (hresp && !hready) begin
          state_d = MST_ERR;
        end else if (hready) begin
          // A single-cycle ERROR is a slave protocol violation; still report it as an error.
          state_d     = MST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_error_d = hresp;
          rsp_rdata_d = (hresp || hwrite_q) ? '0 : rdata_steered;
        end
      end
      MST_ERR: begin
        if (hready) begin
          state_d     = MST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = MST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= MST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hsize_q     <= 2'b00;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      hsel_q      <= hsel_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign hsel      = hsel_q;
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hsize     = hsize_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - directed vector bench for ahb_lite_master acting as its own AHB slave
module tb_ahb_lite_master;

  logic        clk = 1'b0;
  logic        nRst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        hsel;
  logic [6:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ahb_lite_master #(
    .ADDR_WIDTH(7),
    .DATA_WIDTH(32)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rd_bus;
    int          waits;
    logic        err2;
    logic        err1;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_size = v.size; cmd_wdata = v.wdata;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'hFFFF_FFFF;
    chk({tag, " idle cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, " addr htrans"}, 32'(htrans), 32'd2);
    chk({tag, " addr hsel"}, 32'(hsel), 32'd1);
    chk({tag, " addr haddr"}, 32'(haddr), 32'(v.addr));
    chk({tag, " addr hwrite"}, 32'(hwrite), 32'(v.wr));
    chk({tag, " addr hsize"}, 32'(hsize), 32'(v.size));
    @(negedge clk);
    chk({tag, " data htrans"}, 32'(htrans), 32'd0);
    chk({tag, " data hsel"}, 32'(hsel), 32'd0);
    chk({tag, " data cmd_ready"}, 32'(cmd_ready), 32'd0);
    if (v.wr) chk({tag, " data hwdata"}, hwdata, v.exp_hwdata);
    if (v.waits > 0) hready = 1'b0;
    for (int i = 0; i < v.waits; i++) begin
      @(negedge clk);
      chk({tag, " wait rsp_valid"}, 32'(rsp_valid), 32'd0);
      if (v.wr) chk({tag, " wait hwdata"}, hwdata, v.exp_hwdata);
    end
    if (v.err2) begin
      hready = 1'b0; hresp = 1'b1;
      @(negedge clk);
      chk({tag, " err1st rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, " err1st cmd_ready"}, 32'(cmd_ready), 32'd0);
      hready = 1'b1; hresp = 1'b1;
    end else if (v.err1) begin
      hready = 1'b1; hresp = 1'b1;
    end else begin
      hready = 1'b1; hresp = 1'b0; hrdata = v.rd_bus;
    end
    @(negedge clk);
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0BAD_0BAD;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_error"}, 32'(rsp_error), 32'(v.err1 | v.err2));
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " rsp cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk({tag, " pulse end"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rdata held"}, rsp_rdata, v.exp_rdata);
  endtask

  logic [6:0] b2b_addr[3];

  initial begin
    nRst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = 2'b00; cmd_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;

    //  wr    addr    size   wdata          rd_bus         waits err2  err1  exp_hwdata     exp_rdata
    vecs[0] = '{1'b1, 7'h00, 2'b10, 32'hDEADBEEF, 32'h0,        0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 7'h23, 2'b00, 32'h000000A5, 32'h0,        0, 1'b0, 1'b0, 32'hA5000000, 32'h0};
    vecs[2] = '{1'b0, 7'h42, 2'b01, 32'h0,        32'h12345678, 2, 1'b0, 1'b0, 32'h0,        32'h00001234};
    vecs[3] = '{1'b1, 7'h15, 2'b11, 32'hCAFEF00D, 32'h0,        0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 7'h48, 2'b10, 32'h0,        32'h89ABCDEF, 0, 1'b0, 1'b0, 32'h0,        32'h89ABCDEF};
    vecs[5] = '{1'b0, 7'h01, 2'b00, 32'h0,        32'h11223344, 1, 1'b0, 1'b0, 32'h0,        32'h00000033};
    vecs[6] = '{1'b1, 7'h02, 2'b01, 32'h0000BEEF, 32'h0,        0, 1'b0, 1'b0, 32'hBEEF0000, 32'h0};
    vecs[7] = '{1'b0, 7'h10, 2'b10, 32'h0,        32'h55555555, 0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 7'h00, 2'b01, 32'h0,        32'hAABBCCDD, 0, 1'b0, 1'b0, 32'h0,        32'h0000CCDD};
    vecs[9] = '{1'b1, 7'h05, 2'b00, 32'hFFFFFF5A, 32'h0,        0, 1'b0, 1'b0, 32'h00005A00, 32'h0};

    repeat (2) @(negedge clk);
    chk("rst htrans", 32'(htrans), 32'd0);
    chk("rst hsel", 32'(hsel), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst haddr", 32'(haddr), 32'd0);
    nRst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Address phase stretched by hready=0: outputs hold, new command values ignored.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h3C; cmd_size = 2'b10; cmd_wdata = 32'h01020304;
    @(negedge clk);
    hready = 1'b0; cmd_addr = 7'h11; cmd_write = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("addrwait htrans", 32'(htrans), 32'd2);
      chk("addrwait haddr", 32'(haddr), 32'h3C);
      chk("addrwait hwrite", 32'(hwrite), 32'd1);
    end
    hready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("addrwait hwdata", hwdata, 32'h01020304);
    @(negedge clk);
    chk("addrwait rsp_valid", 32'(rsp_valid), 32'd1);

    // cmd_valid held across three writes: one acceptance per IDLE visit.
    b2b_addr[0] = 7'h00; b2b_addr[1] = 7'h23; b2b_addr[2] = 7'h3F;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'b00; cmd_wdata = 32'h000000C3;
    for (int k = 0; k < 3; k++) begin
      cmd_addr = b2b_addr[k];
      @(negedge clk);
      chk("b2b addr htrans", 32'(htrans), 32'd2);
      chk("b2b addr haddr", 32'(haddr), 32'(b2b_addr[k]));
      chk("b2b addr rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("b2b data cmd_ready", 32'(cmd_ready), 32'd0);
      chk("b2b data hwdata", hwdata, 32'h000000C3 << (8 * int'(b2b_addr[k][1:0])));
      @(negedge clk);
      chk("b2b rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b rsp cmd_ready", 32'(cmd_ready), 32'd1);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b idle after", 32'(htrans), 32'd0);

    // Asynchronous reset while waiting in the data phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h2A; cmd_size = 2'b10; cmd_wdata = 32'h77777777;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    hready = 1'b0;
    chk("mid hwdata", hwdata, 32'h77777777);
    #2 nRst = 1'b0;
    #1;
    chk("midrst hwdata", hwdata, 32'd0);
    chk("midrst haddr", 32'(haddr), 32'd0);
    chk("midrst hwrite", 32'(hwrite), 32'd0);
    chk("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    hready = 1'b1;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postrst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("postrst htrans", 32'(htrans), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
